// File: rtl/slc_run_sequencer.sv
// slc_run_sequencer: one-shot Reset -> S setup -> Run -> N x Continue button sequencer for SLC-3.
// Define SEQ_HANDSHAKE_EN to end each GAP on pause_seen, with a GAP watchdog driving err.
module slc_run_sequencer #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8,
  parameter int PULSE_CYC = 5,
  parameter int SETUP_CYC = 50,
  parameter int GAP_CYC   = 25
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] start_addr,
  input  logic [DATA_W-1:0] next_sw,
  input  logic [CNT_W-1:0]  n_cont,
  input  logic              pause_seen,
  output logic              cpu_reset_n,
  output logic              run_n,
  output logic              continue_n,
  output logic [DATA_W-1:0] S,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef SEQ_HANDSHAKE_EN
  localparam int WD_CYC = 16 * GAP_CYC;
  localparam int MAX_A  = (WD_CYC > SETUP_CYC) ? WD_CYC : SETUP_CYC;
`else
  localparam int MAX_A  = (GAP_CYC > SETUP_CYC) ? GAP_CYC : SETUP_CYC;
`endif
  localparam int MAX_CYC = (MAX_A > PULSE_CYC) ? MAX_A : PULSE_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
`ifdef SEQ_HANDSHAKE_EN
  // In handshake mode the GAP timer doubles as the watchdog.
  localparam logic [TW-1:0] GAP_LD   = TW'(WD_CYC - 1);
`else
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SETUP,
    ST_RUN,
    ST_GAP,
    ST_CONT,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [CNT_W-1:0]  cont_q, cont_d;
  logic [CNT_W-1:0]  n_cont_q, n_cont_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] nsw_q, nsw_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              cpu_reset_n_q, cpu_reset_n_d;
  logic              run_n_q, run_n_d;
  logic              continue_n_q, continue_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SEQ_HANDSHAKE_EN
  logic              err_q, err_d;
`else
  logic              unused_pause_seen;
  assign unused_pause_seen = pause_seen;
`endif

  logic             tmr_zero;
  logic [CNT_W-1:0] cont_inc;

  assign tmr_zero = (tmr_q == '0);
  assign cont_inc = cont_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_zero ? tmr_q : tmr_q - TW'(1);
    cont_d        = cont_q;
    n_cont_d      = n_cont_q;
    addr_d        = addr_q;
    nsw_d         = nsw_q;
    s_d           = s_q;
    cpu_reset_n_d = cpu_reset_n_q;
    run_n_d       = run_n_q;
    continue_n_d  = continue_n_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
`ifdef SEQ_HANDSHAKE_EN
    err_d         = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d       = ST_RST;
          tmr_d         = PULSE_LD;
          cont_d        = '0;
          n_cont_d      = n_cont;
          addr_d        = start_addr;
          nsw_d         = next_sw;
          cpu_reset_n_d = 1'b0;
          busy_d        = 1'b1;
`ifdef SEQ_HANDSHAKE_EN
          err_d         = 1'b0;
`endif
        end
      end
      ST_RST: begin
        if (tmr_zero) begin
          state_d       = ST_SETUP;
          tmr_d         = SETUP_LD;
          cpu_reset_n_d = 1'b1;
          s_d           = addr_q;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d = ST_RUN;
          tmr_d   = PULSE_LD;
          run_n_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (tmr_zero) begin
          run_n_d = 1'b1;
          if (n_cont_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            tmr_d   = GAP_LD;
          end
        end
      end
      ST_GAP: begin
`ifdef SEQ_HANDSHAKE_EN
        if (pause_seen) begin
          state_d      = ST_CONT;
          tmr_d        = PULSE_LD;
          continue_n_d = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
`else
        if (tmr_zero) begin
          state_d      = ST_CONT;
          tmr_d        = PULSE_LD;
          continue_n_d = 1'b0;
        end
`endif
      end
      ST_CONT: begin
        if (tmr_zero) begin
          continue_n_d = 1'b1;
          cont_d       = cont_inc;
          // S switches to the program's input value once the first Continue is released.
          if (cont_q == '0) s_d = nsw_q;
          if (cont_inc == n_cont_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            tmr_d   = GAP_LD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort releases every button but leaves S where it was.
    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      cpu_reset_n_d = 1'b1;
      run_n_d       = 1'b1;
      continue_n_d  = 1'b1;
      busy_d        = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      cont_q        <= '0;
      n_cont_q      <= '0;
      addr_q        <= '0;
      nsw_q         <= '0;
      s_q           <= '0;
      cpu_reset_n_q <= 1'b1;
      run_n_q       <= 1'b1;
      continue_n_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SEQ_HANDSHAKE_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      cont_q        <= cont_d;
      n_cont_q      <= n_cont_d;
      addr_q        <= addr_d;
      nsw_q         <= nsw_d;
      s_q           <= s_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      run_n_q       <= run_n_d;
      continue_n_q  <= continue_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef SEQ_HANDSHAKE_EN
      err_q         <= err_d;
`endif
    end
  end

  assign cpu_reset_n = cpu_reset_n_q;
  assign run_n       = run_n_q;
  assign continue_n  = continue_n_q;
  assign S           = s_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef SEQ_HANDSHAKE_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_slc_run_sequencer.sv
// tb_slc_run_sequencer: randomized sequences checked against a timeline model of the button schedule.
// Covers reset, abort, ignored restarts, async Reset, and the SEQ_HANDSHAKE_EN watchdog when defined.
module tb_slc_run_sequencer;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int P  = 2;
  localparam int SU = 4;
  localparam int G  = 3;

  logic          Clk = 1'b0;
  logic          Reset, start, abort, pause_seen;
  logic [DW-1:0] start_addr, next_sw, S;
  logic [CW-1:0] n_cont;
  logic          cpu_reset_n, run_n, continue_n, busy, done, err;

  slc_run_sequencer #(
    .DATA_W(DW), .CNT_W(CW), .PULSE_CYC(P), .SETUP_CYC(SU), .GAP_CYC(G)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .start_addr(start_addr), .next_sw(next_sw), .n_cont(n_cont), .pause_seen(pause_seen),
    .cpu_reset_n(cpu_reset_n), .run_n(run_n), .continue_n(continue_n),
    .S(S), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: m_t counts cycles since the accepting edge (cycle 1 = first RST cycle).
  bit            m_busy;
  int            m_t, m_n;
  logic [DW-1:0] m_sa, m_ns, m_s;
  bit            m_abort_edge;
  int            w_rst, w_run, w_cont;
  int            d_done, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int done_t(input int n);
    return 1 + 2*P + SU + n*(G+P);
  endfunction

  function automatic bit gap_last_now();
    int u;
    u = m_t - (2*P + SU + 1);
    return m_busy && (u >= 0) && (m_t < done_t(m_n)) && ((u % (G+P)) == G-1);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_n = 0; m_sa = '0; m_ns = '0; m_s = '0;
    m_abort_edge = 0; w_rst = 0; w_run = 0; w_cont = 0;
  endtask

  task automatic model_edge();
    m_abort_edge = 0;
    if (m_busy) begin
      if (abort) begin
        m_busy = 0;
        m_abort_edge = 1;
      end else if (m_t == done_t(m_n)) begin
        m_busy = 0;
      end else begin
        m_t++;
        if (m_t == P + 1) m_s = m_sa;
        if (m_n > 0 && m_t == 2*P + SU + G + P + 1) m_s = m_ns;
      end
    end else if (start && !abort) begin
      m_busy = 1; m_t = 1;
      m_sa = start_addr; m_ns = next_sw; m_n = int'(n_cont);
    end
  endtask

  task automatic track_width(input string tag, input logic b, inout int w);
    if (!b) w++;
    else begin
      if (w > 0 && !m_abort_edge) chk(tag, 32'(w), 32'(P));
      w = 0;
    end
  endtask

  task automatic check_outputs();
    logic e_rst, e_run, e_cont, e_done;
    int u, nlow;
    e_rst = 1; e_run = 1; e_cont = 1; e_done = 0;
    if (m_busy) begin
      if (m_t <= P) e_rst = 0;
      if (m_t >= P + SU + 1 && m_t <= 2*P + SU) e_run = 0;
      u = m_t - (2*P + SU + 1);
      if (u >= 0 && m_t < done_t(m_n) && (u % (G+P)) >= G) e_cont = 0;
      e_done = (m_t == done_t(m_n));
    end
    chk("cpu_reset_n", 32'(cpu_reset_n), 32'(e_rst));
    chk("run_n",       32'(run_n),       32'(e_run));
    chk("continue_n",  32'(continue_n),  32'(e_cont));
    chk("busy",        32'(busy),        32'(m_busy));
    chk("done",        32'(done),        32'(e_done));
    chk("S",           32'(S),           32'(m_s));
    chk("err",         32'(err),         32'(0));
    nlow = int'(!cpu_reset_n) + int'(!run_n) + int'(!continue_n);
    chk("one_button_low", 32'(nlow <= 1), 32'(1));
    track_width("rst_width",  cpu_reset_n, w_rst);
    track_width("run_width",  run_n,       w_run);
    track_width("cont_width", continue_n,  w_cont);
    d_done += int'(done);
    m_done += int'(e_done);
  endtask

  task automatic tick();
`ifdef SEQ_HANDSHAKE_EN
    pause_seen = gap_last_now();
`else
    pause_seen = 1'($urandom);
`endif
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_seq(input logic [DW-1:0] sa, input logic [DW-1:0] ns, input int nc,
                         input int abort_at, input int restart_at);
    int budget;
    start = 1; abort = 0; start_addr = sa; next_sw = ns; n_cont = CW'(nc);
    tick();
    start = 0;
    budget = 0;
    while (m_busy && budget < 200) begin
      start_addr = DW'($urandom);
      next_sw    = DW'($urandom);
      n_cont     = CW'($urandom_range(0, 7));
      start      = (m_t == restart_at);
      abort      = (m_t == abort_at);
      tick();
      budget++;
    end
    start = 0; abort = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(1));
    chk({tag, "_run_n"},       32'(run_n),       32'(1));
    chk({tag, "_continue_n"},  32'(continue_n),  32'(1));
    chk({tag, "_S"},           32'(S),           32'(0));
    chk({tag, "_busy"},        32'(busy),        32'(0));
    chk({tag, "_done"},        32'(done),        32'(0));
    chk({tag, "_err"},         32'(err),         32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1; start = 0; abort = 0; pause_seen = 0;
    start_addr = '0; next_sw = '0; n_cont = '0;
    d_done = 0; m_done = 0;
    model_reset();
    #12;
    check_reset_vals("por");
    Reset = 0;

    run_seq(16'h005A, 16'h0606, 2, -1, -1);
    run_seq(16'h0003, 16'h1234, 0, -1, -1);
    chk("ncont0_S_kept", 32'(S), 32'h0003);
    run_seq(16'h005A, 16'h0606, 2, 12, -1);
    chk("abort_S_held", 32'(S), 32'h005A);

    // Restart attempt while busy, then async Reset in cycle k+10.
    start = 1; start_addr = 16'h0BAD; next_sw = 16'h0F0F; n_cont = 8'd3;
    tick();
    start = 0;
    while (m_t < 10) begin
      start = (m_t == 5);
      tick();
    end
    start = 0;
    #2 Reset = 1;
    #1 check_reset_vals("async_rst");
    model_reset();
    #1 Reset = 0;
    tick();

    // start and abort together in IDLE: nothing starts.
    start = 1; abort = 1; start_addr = 16'h7777;
    tick();
    start = 0; abort = 0;
    chk("start_abort_idle", 32'(busy), 32'(0));

    for (int i = 0; i < 40; i++) begin
      int nc, ab_at, rs_at;
      nc    = int'($urandom_range(0, 4));
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, done_t(nc))) : -1;
      rs_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, done_t(nc))) : -1;
      run_seq(DW'($urandom), DW'($urandom), nc, ab_at, rs_at);
      repeat ($urandom_range(0, 3)) begin
        abort = 1'($urandom);
        tick();
      end
      abort = 0;
    end
    chk("done_count", 32'(d_done), 32'(m_done));

`ifdef SEQ_HANDSHAKE_EN
    pause_seen = 0; start_addr = 16'h0011; next_sw = 16'h0022; n_cont = 8'd1; start = 1;
    @(posedge Clk); #1;
    start = 0;
    chk("hs_err_clear", 32'(err), 32'(0));
    for (int t = 2; t <= 57; t++) begin
      @(posedge Clk); #1;
      if (t == 56) begin
        chk("hs_wd_busy_pre", 32'(busy), 32'(1));
        chk("hs_wd_err_pre",  32'(err),  32'(0));
      end
    end
    chk("hs_wd_err",  32'(err),        32'(1));
    chk("hs_wd_idle", 32'(busy),       32'(0));
    chk("hs_wd_cont", 32'(continue_n), 32'(1));
    repeat (3) @(posedge Clk);
    #1 chk("hs_err_sticky", 32'(err), 32'(1));
    start = 1;
    @(posedge Clk); #1;
    start = 0;
    chk("hs_err_start_clr", 32'(err), 32'(0));
    for (int t = 2; t <= 16; t++) begin
      pause_seen = (t == 14);
      @(posedge Clk); #1;
      if (t == 13) chk("hs_gap_wait", 32'(continue_n), 32'(1));
      if (t == 14 || t == 15) chk("hs_cont_low", 32'(continue_n), 32'(0));
      if (t == 16) begin
        chk("hs_cont_rel", 32'(continue_n), 32'(1));
        chk("hs_done",     32'(done),       32'(1));
      end
    end
    pause_seen = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
